shift_exec_stage: RTL and testbench
===================================

# shift_exec_stage

Execute-stage shift unit of the RV32I core: accepts decoded shift micro-ops (SLL/SRL/SRA, optional ROR) from the issue stage, selects the shift amount from register or immediate, computes the result through a single right-shift datapath, and presents it to writeback through a registered valid/ready interface. A 2-entry skid buffer gives full throughput with a registered `in_ready`; latency is one cycle.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `SHAMT_W`, 5, shift-amount width, `$clog2(XLEN)`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  micro-op present.
- `in_ready`  out  1  stage can accept; registered.
- `in_op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- `in_src_imm`  in  1  1: shamt from `in_imm_shamt`; 0: from `in_op_b[4:0]`.
- `in_op_a`  in  XLEN  value to shift (rs1).
- `in_op_b`  in  XLEN  rs2 value.
- `in_imm_shamt`  in  SHAMT_W  immediate shamt.
- `in_rd`  in  5  destination register tag.
- `flush`  in  1  pipeline kill; synchronous.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  XLEN  shifted value.
- `out_rd`  out  5  tag travelling with result.
- `out_illegal`  out  1  op 11 received while rotates compiled out.

## Operation
- Transfer on `in_valid && in_ready`; out transfer on `out_valid && out_ready`.
- shamt = `in_src_imm ? in_imm_shamt : in_op_b[4:0]`; upper bits of `in_op_b` ignored.
- SRL: `a >> s`; SRA: arithmetic, sign = `a[31]`; SLL: bit-reverse `a`, logical right shift, bit-reverse result; ROR: `(a >> s) | (a << (32-s))`, s=0 returns `a`.
- Result computed combinationally on input side, captured into the buffer; nothing is recomputed on output side.
- Buffer states: EMPTY (0 entries), ONE (1), FULL (2). `in_ready` = state != FULL, registered.
  - EMPTY: in-xfer -> ONE.
  - ONE: in-xfer without out-xfer -> FULL; out-xfer without in-xfer -> EMPTY; both -> ONE (new entry replaces head).
  - FULL: out-xfer -> ONE (skid entry becomes head); no input accepted.
- Ordering strictly FIFO; `out_*` driven from head entry only, stable while `out_valid && !out_ready`.
- `flush`: next cycle state EMPTY, `out_valid`=0, `in_ready`=1; an input presented in the flush cycle is dropped; an output handshake in the flush cycle still counts as delivered (consumer's view).
- Reset (any time, including mid-transfer): state EMPTY; `out_valid`=0, `in_ready`=0 during reset, 1 from first clock edge after deassertion; `out_result`=0, `out_rd`=0, `out_illegal`=0.

## Timing
- Latency: input accepted at edge N -> `out_valid` high after edge N (visible cycle N+1) when buffer was empty.
- Throughput: one op/cycle while `out_ready`=1.
- Backpressure: with `out_ready` low, accepts exactly 2 ops, then `in_ready` falls the cycle after the second transfer.
- No combinational path from `out_ready` to `in_ready` or from `in_*` to `out_*`.

## Configuration
- `SHIFT_ROT_EN` defined: op 11 performs ROR as above; `out_illegal` tied 0.
- Undefined: op 11 produces `out_result`=0 with `out_illegal`=1 carried alongside `out_rd`; rotate logic absent.

## Structure
- Package `shift_pkg`: op-code localparams (`SHIFT_OP_SLL/SRL/SRA/ROR`), `XLEN`, `SHAMT_W`, packed struct `shift_entry_t` {result, rd, illegal}.
- Sub-module `shift_skid_buf`: generic 2-entry valid/ready skid buffer of `shift_entry_t` with flush; the stage holds only operand select and shift datapath.

## Test plan
- SRA a=32'h8000_0000, imm shamt 4 -> `out_result`=32'hF800_0000, one cycle later.
- SLL a=32'h0000_0001, rs2=32'hFFFF_FFE3 (shamt 3, upper bits ignored) -> 32'h0000_0008.
- ROR a=32'h0000_00F1, shamt 4 -> 32'h1000_000F with macro; without macro -> result 0, `out_illegal`=1.
- `out_ready`=0, 3 back-to-back ops -> first two accepted, `in_ready`=0, third held; release -> results in order, no loss/dup.
- `flush` with FULL buffer and concurrent `in_valid` -> next cycle `out_valid`=0, `in_ready`=1, no dropped op appears.
- `rst_n` pulsed low mid-stream -> all outputs zero immediately, EMPTY after release.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the execute-stage shift unit
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
    localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
    localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
    localparam logic [1:0] SHIFT_OP_ROR = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            illegal;
    } shift_entry_t;

    // Left shifts reuse the right shifter by mirroring the operand and the result.
    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_skid_buf.sv
// rtl/shift_skid_buf.sv - 2-entry valid/ready skid buffer of shift_entry_t with flush
module shift_skid_buf
    import shift_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  shift_entry_t in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output shift_entry_t out_data
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    buf_state_t   state;
    buf_state_t   state_nxt;
    logic         ready_q;
    shift_entry_t head;
    shift_entry_t skid;
    logic         in_xfer;
    logic         out_xfer;
    logic         load_head;
    logic         load_skid;
    logic         head_from_skid;

    assign in_ready  = ready_q;
    assign out_valid = (state != BUF_EMPTY);
    assign out_data  = head;
    assign in_xfer   = in_valid && ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BUF_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != BUF_FULL);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (in_xfer) begin
                    state_nxt = BUF_ONE;
                    load_head = 1'b1;
                end
            end
            BUF_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_nxt = BUF_FULL;
                    load_skid = 1'b1;
                end else if (!in_xfer && out_xfer) begin
                    state_nxt = BUF_EMPTY;
                end else if (in_xfer && out_xfer) begin
                    load_head = 1'b1;
                end
            end
            BUF_FULL: begin
                if (out_xfer) begin
                    state_nxt      = BUF_ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
        // Flush discards everything, including an input offered this cycle.
        if (flush) begin
            state_nxt      = BUF_EMPTY;
            load_head      = 1'b0;
            load_skid      = 1'b0;
            head_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head) begin
                head <= in_data;
            end else if (head_from_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= in_data;
            end
        end
    end

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - RV32I execute-stage shift unit; SHIFT_ROT_EN enables ROR for op 11
module shift_exec_stage
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic               in_src_imm,
    input  logic [XLEN-1:0]    in_op_a,
    input  logic [XLEN-1:0]    in_op_b,
    input  logic [SHAMT_W-1:0] in_imm_shamt,
    input  logic [4:0]         in_rd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [4:0]         out_rd,
    output logic               out_illegal
);

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    low_word;
    logic [XLEN-1:0]    high_word;
    logic [2*XLEN-1:0]  shift_wide;
    logic [XLEN-1:0]    shifted;
    logic               illegal;
    shift_entry_t       entry;
    shift_entry_t       head;
    logic               unused_bits;

    assign shamt = in_src_imm ? in_imm_shamt : in_op_b[SHAMT_W-1:0];

    // One right shifter over {high_word, low_word}: high_word supplies the fill
    // (zeros, sign copies, or the operand itself for a rotate).
    always_comb begin
        low_word  = (in_op == SHIFT_OP_SLL) ? bit_rev(in_op_a) : in_op_a;
        high_word = '0;
        illegal   = 1'b0;
        case (in_op)
            SHIFT_OP_SRA: high_word = {XLEN{in_op_a[XLEN-1]}};
`ifdef SHIFT_ROT_EN
            SHIFT_OP_ROR: high_word = in_op_a;
`else
            SHIFT_OP_ROR: illegal   = 1'b1;
`endif
            default:      high_word = '0;
        endcase
    end

    assign shift_wide = {high_word, low_word} >> shamt;
    assign shifted    = shift_wide[XLEN-1:0];

    always_comb begin
        entry         = '0;
        entry.rd      = in_rd;
        entry.illegal = illegal;
        if (illegal) begin
            entry.result = '0;
        end else if (in_op == SHIFT_OP_SLL) begin
            entry.result = bit_rev(shifted);
        end else begin
            entry.result = shifted;
        end
    end

    assign unused_bits = ^{in_op_b[XLEN-1:SHAMT_W], shift_wide[2*XLEN-1:XLEN]};

    shift_skid_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_result  = head.result;
    assign out_rd      = head.rd;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - directed self-checking bench for shift_exec_stage
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_src_imm;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic [4:0]  in_imm_shamt;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    shift_exec_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_src_imm   (in_src_imm),
        .in_op_a      (in_op_a),
        .in_op_b      (in_op_b),
        .in_imm_shamt (in_imm_shamt),
        .in_rd        (in_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_illegal  (out_illegal)
    );

    typedef struct {
        logic [1:0]  op;
        logic        imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    task automatic drive(input logic [1:0] op, input logic imm, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_op        = op;
        in_src_imm   = imm;
        in_op_a      = a;
        in_op_b      = b;
        in_imm_shamt = sh;
        in_rd        = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_src_imm = 1'b0;
        in_op_a = '0; in_op_b = '0; in_imm_shamt = '0; in_rd = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vec++; if (out_result !== 32'h0) begin errs++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
        vec++; if (out_rd !== 5'h0 || out_illegal !== 1'b0) begin errs++; $display("FAIL reset_rd_illegal: got %h/%b expected 0/0", out_rd, out_illegal); end
        rst_n = 1'b1;
        #1;
        vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL release_in_ready_early: got %b expected 0", in_ready); end
        @(negedge clk);
        vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_ops();
        vec_t tbl[10];
        tbl[0] = '{2'b10, 1'b1, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'hF800_0000, 1'b0};
        tbl[1] = '{2'b00, 1'b0, 32'h0000_0001, 32'hFFFF_FFE3, 5'd0,  32'h0000_0008, 1'b0};
        tbl[2] = '{2'b01, 1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0};
        tbl[3] = '{2'b10, 1'b0, 32'h7FFF_FFFF, 32'h0000_001F, 5'd0,  32'h0000_0000, 1'b0};
        tbl[4] = '{2'b00, 1'b1, 32'h1234_5678, 32'h0000_0007, 5'd0,  32'h1234_5678, 1'b0};
        tbl[5] = '{2'b10, 1'b0, 32'h8000_0001, 32'h0000_0020, 5'd9,  32'h8000_0001, 1'b0};
        tbl[6] = '{2'b00, 1'b1, 32'h8000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000, 1'b0};
`ifdef SHIFT_ROT_EN
        tbl[7] = '{2'b11, 1'b1, 32'h0000_00F1, 32'h0000_0000, 5'd4,  32'h1000_000F, 1'b0};
        tbl[8] = '{2'b11, 1'b1, 32'hABCD_1234, 32'h0000_0000, 5'd0,  32'hABCD_1234, 1'b0};
`else
        tbl[7] = '{2'b11, 1'b1, 32'h0000_00F1, 32'h0000_0000, 5'd4,  32'h0000_0000, 1'b1};
        tbl[8] = '{2'b11, 1'b1, 32'hABCD_1234, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b1};
`endif
        tbl[9] = '{2'b10, 1'b1, 32'hF0F0_F0F0, 32'h0000_0003, 5'd8,  32'hFFF0_F0F0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].imm, tbl[i].a, tbl[i].b, tbl[i].sh, 5'(i + 1));
            @(negedge clk);
            in_valid = 1'b0;
            vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL op%0d_valid: got %b expected 1", i, out_valid); end
            vec++; if (out_result !== tbl[i].exp) begin errs++; $display("FAIL op%0d_result: got %h expected %h", i, out_result, tbl[i].exp); end
            vec++; if (out_rd !== 5'(i + 1)) begin errs++; $display("FAIL op%0d_rd: got %0d expected %0d", i, out_rd, i + 1); end
            vec++; if (out_illegal !== tbl[i].ill) begin errs++; $display("FAIL op%0d_illegal: got %b expected %b", i, out_illegal, tbl[i].ill); end
            @(negedge clk);
            vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL op%0d_drain: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_v[4];
        logic [31:0] e_v[4];
        a_v[0] = 32'h10; a_v[1] = 32'h20; a_v[2] = 32'h40; a_v[3] = 32'h80;
        e_v[0] = 32'h08; e_v[1] = 32'h10; e_v[2] = 32'h20; e_v[3] = 32'h40;
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vec++; if (out_valid !== 1'b1 || out_result !== e_v[i-1] || out_rd !== 5'(10 + i - 1))
                    begin errs++; $display("FAIL b2b%0d: got v=%b %h rd=%0d expected v=1 %h rd=%0d", i, out_valid, out_result, out_rd, e_v[i-1], 10 + i - 1); end
            end
            vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready%0d: got %b expected 1", i, in_ready); end
            if (i < 4) drive(2'b01, 1'b1, a_v[i], 32'h0, 5'd1, 5'(10 + i));
            else in_valid = 1'b0;
        end
        @(negedge clk);
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        @(negedge clk);
        drive(2'b00, 1'b1, 32'h3, 32'h0, 5'd2, 5'd21);
        @(negedge clk);
        vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_after1: got %b expected 1", in_ready); end
        drive(2'b01, 1'b1, 32'h100, 32'h0, 5'd4, 5'd22);
        @(negedge clk);
        vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        drive(2'b10, 1'b1, 32'hFFFF_0000, 32'h0, 5'd16, 5'd23);
        @(negedge clk);
        vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hC || out_rd !== 5'd21)
            begin errs++; $display("FAIL bp_hold: got rdy=%b v=%b %h rd=%0d expected rdy=0 v=1 0000000c rd=21", in_ready, out_valid, out_result, out_rd); end
        out_ready = 1'b1;
        @(negedge clk);
        vec++; if (out_valid !== 1'b1 || out_result !== 32'h10 || out_rd !== 5'd22 || in_ready !== 1'b1)
            begin errs++; $display("FAIL bp_second: got v=%b %h rd=%0d rdy=%b expected v=1 00000010 rd=22 rdy=1", out_valid, out_result, out_rd, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        vec++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF || out_rd !== 5'd23)
            begin errs++; $display("FAIL bp_third: got v=%b %h rd=%0d expected v=1 ffffffff rd=23", out_valid, out_result, out_rd); end
        @(negedge clk);
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(negedge clk);
        drive(2'b00, 1'b1, 32'h1, 32'h0, 5'd1, 5'd1);
        @(negedge clk);
        drive(2'b00, 1'b1, 32'h1, 32'h0, 5'd2, 5'd2);
        @(negedge clk);
        vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_pre_full: got %b expected 0", in_ready); end
        drive(2'b01, 1'b1, 32'hDEAD, 32'h0, 5'd0, 5'd30);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_full: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
        drive(2'b01, 1'b1, 32'h4, 32'h0, 5'd1, 5'd3);
        @(negedge clk);
        drive(2'b01, 1'b1, 32'hBEEF, 32'h0, 5'd0, 5'd31);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_one: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
        repeat (2) @(negedge clk);
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_no_ghost: got %b expected 0", out_valid); end
        drive(2'b01, 1'b1, 32'h40, 32'h0, 5'd2, 5'd4);
        @(negedge clk);
        in_valid = 1'b0;
        vec++; if (out_valid !== 1'b1 || out_result !== 32'h10 || out_rd !== 5'd4)
            begin errs++; $display("FAIL flush_recover: got v=%b %h rd=%0d expected v=1 00000010 rd=4", out_valid, out_result, out_rd); end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        @(negedge clk);
        drive(2'b11, 1'b1, 32'hF1, 32'h0, 5'd4, 5'd7);
        @(negedge clk);
        drive(2'b10, 1'b1, 32'h8000_0000, 32'h0, 5'd1, 5'd8);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL rst_mid_hs: got v=%b rdy=%b expected 0/0", out_valid, in_ready); end
        vec++; if (out_result !== 32'h0 || out_rd !== 5'h0 || out_illegal !== 1'b0)
            begin errs++; $display("FAIL rst_mid_data: got %h rd=%0d ill=%b expected 0", out_result, out_rd, out_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_release: got rdy=%b v=%b expected 1/0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
